// File: rtl/pipe_adder_pkg.sv
// Shared constants and the per-stage payload carried down the adder pipeline.
package pipe_adder_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_STAGES_DEF = 4;

    // Payload vectors are sized for the widest supported datapath; narrower
    // instances use only the low DATA_WIDTH bits.
    localparam int MAX_WIDTH = 64;

    // opA/opB hold the slices not yet added, shifted down so that the slice a
    // stage consumes always sits in the low bits. result collects finished
    // slices in place. signB is the sign of the effective (possibly inverted)
    // second operand. carry is the ripple into the next stage.
    typedef struct packed {
        logic                 valid;
        logic                 sub;
        logic                 sat;
        logic                 signA;
        logic                 signB;
        logic                 carry;
        logic [MAX_WIDTH-1:0] opA;
        logic [MAX_WIDTH-1:0] opB;
        logic [MAX_WIDTH-1:0] result;
    } stage_t;

endpackage

// File: rtl/adder_slice.sv
// One W-bit ripple slice of the pipelined adder: a + b + cin with carry out.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    // Extend to W+1 bits so the carry falls out of the top of the sum.
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with saturation. Each stage adds one W-bit slice and
// passes the carry, the remaining operand slices and the finished result
// slices to the next stage. A stalled output freezes the whole pipeline.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_STAGES = NUM_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic                  sub,
    input  logic                  sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W = DATA_WIDTH / NUM_STAGES;

    if ((NUM_STAGES < 1) || (DATA_WIDTH > MAX_WIDTH) || ((DATA_WIDTH % NUM_STAGES) != 0)) begin : gBadParams
        $error("pipe_adder: DATA_WIDTH must be divisible by NUM_STAGES and at most MAX_WIDTH");
    end

    stage_t                stageIn   [NUM_STAGES];
    stage_t                stage_d   [NUM_STAGES];
    stage_t                stage_q   [NUM_STAGES];
    logic [W-1:0]          sliceSum  [NUM_STAGES];
    logic                  sliceCarry[NUM_STAGES];
    logic [DATA_WIDTH-1:0] effB;
    logic [DATA_WIDTH-1:0] rawSum;
    logic                  ovfRaw;
    logic                  stall;

    // Subtraction is din1 + ~din2 with the +1 supplied as stage 0 carry-in.
    assign effB = sub ? ~din2 : din2;

    // Stage inputs: stage 0 is fed from the ports, later stages from the
    // register of the stage before them.
    always_comb begin
        stageIn[0]        = '0;
        stageIn[0].valid  = in_valid && !flush;
        stageIn[0].sub    = sub;
        stageIn[0].sat    = sat;
        stageIn[0].signA  = din1[DATA_WIDTH-1];
        stageIn[0].signB  = effB[DATA_WIDTH-1];
        stageIn[0].carry  = sub;
        stageIn[0].opA    = MAX_WIDTH'(din1);
        stageIn[0].opB    = MAX_WIDTH'(effB);
        for (int k = 1; k < NUM_STAGES; k++) begin
            stageIn[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : gSlice
        adder_slice #(
            .W(W)
        ) uSlice (
            .a_i   (stageIn[k].opA[W-1:0]),
            .b_i   (stageIn[k].opB[W-1:0]),
            .cin_i (stageIn[k].carry),
            .sum_o (sliceSum[k]),
            .cout_o(sliceCarry[k])
        );
    end

    // Next payload per stage: drop the consumed operand slice, drop the new
    // result slice into place and forward the slice carry.
    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_d[k]                    = stageIn[k];
            stage_d[k].opA                = stageIn[k].opA >> W;
            stage_d[k].opB                = stageIn[k].opB >> W;
            stage_d[k].result[k*W +: W]   = sliceSum[k];
            stage_d[k].carry              = sliceCarry[k];
        end
    end

    assign stall    = stage_q[NUM_STAGES-1].valid && !out_ready;
    assign in_ready = !stall;

    // Pipeline registers: reset wipes everything, flush kills only valids,
    // and a stalled output holds every stage in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k].valid <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Overflow and optional clamp on the completed result; the clamp direction
    // follows the sign of the first operand.
    always_comb begin
        rawSum = stage_q[NUM_STAGES-1].result[DATA_WIDTH-1:0];
        ovfRaw = (stage_q[NUM_STAGES-1].signA == stage_q[NUM_STAGES-1].signB) &&
                 (rawSum[DATA_WIDTH-1] != stage_q[NUM_STAGES-1].signA);
        dout   = rawSum;
        if (stage_q[NUM_STAGES-1].sat && ovfRaw) begin
            dout = stage_q[NUM_STAGES-1].signA ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    assign ovf       = ovfRaw;
    assign cout      = stage_q[NUM_STAGES-1].carry;
    assign out_valid = stage_q[NUM_STAGES-1].valid;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder at the default 32-bit, 4-stage setup.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din1;
    logic [31:0] din2;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;
    logic        cout;
    logic        ovf;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [31:0] din1;
        logic [31:0] din2;
        logic        sub;
        logic        sat;
        logic [31:0] expDout;
        logic        expCout;
        logic        expOvf;
    } vec_t;

    typedef struct packed {
        logic [31:0] dout;
        logic        cout;
        logic        ovf;
    } res_t;

    vec_t vecs[11];

    pipe_adder dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din1     (din1),
        .din2     (din2),
        .sub      (sub),
        .sat      (sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .cout     (cout),
        .ovf      (ovf)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case some wait is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference behaviour from plain integer arithmetic: signed ideal result
    // decides overflow, unsigned magnitudes decide carry/borrow.
    function automatic res_t refModel(input logic [31:0] a, input logic [31:0] b,
                                      input logic s, input logic st);
        res_t   r;
        longint ideal;
        longint ua;
        longint ub;
        ua    = longint'(a);
        ub    = longint'(b);
        ideal = s ? (longint'($signed(a)) - longint'($signed(b)))
                  : (longint'($signed(a)) + longint'($signed(b)));
        r.dout = ideal[31:0];
        r.cout = s ? (ua >= ub) : ((ua + ub) >= 64'sd4294967296);
        r.ovf  = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
        if (st && r.ovf) begin
            r.dout = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return r;
    endfunction

    task automatic checkOutput(input string what, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    // Present one operation, then count negedges until its result appears.
    task automatic applyStimulus(input vec_t v, output int lat);
        @(negedge clk);
        din1     = v.din1;
        din2     = v.din2;
        sub      = v.sub;
        sat      = v.sat;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int lat;
        applyStimulus(v, lat);
        checkOutput({tag, "_latency"}, lat, 4);
        checkOutput({tag, "_dout"}, dout, v.expDout);
        checkOutput({tag, "_cout"}, cout, v.expCout);
        checkOutput({tag, "_ovf"}, ovf, v.expOvf);
    endtask

    task automatic watchQuiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput(tag, seen, 0);
    endtask

    // Random back-to-back stream against a queue scoreboard. Pattern mode
    // drives out_ready as 1,0,0,1 repeating; otherwise out_ready is random.
    task automatic streamTest(input string tag, input int numOps, input bit randomReady);
        res_t       expQ[$];
        res_t       e;
        int         sent    = 0;
        int         got     = 0;
        int         cycles  = 0;
        logic [3:0] pattern = 4'b1001;
        bit         inFire;
        bit         outFire;
        while (got < numOps && cycles < 600) begin
            @(negedge clk);
            out_ready = randomReady ? 1'($urandom_range(0, 1)) : pattern[cycles % 4];
            if (sent < numOps) begin
                din1     = $urandom;
                din2     = $urandom;
                sub      = 1'($urandom_range(0, 1));
                sat      = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checkOutput({tag, "_in_ready"}, in_ready, !(out_valid && !out_ready));
            inFire  = in_valid && in_ready;
            outFire = out_valid && out_ready;
            if (outFire) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, "_spurious"}, 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({tag, "_dout"}, dout, e.dout);
                    checkOutput({tag, "_cout"}, cout, e.cout);
                    checkOutput({tag, "_ovf"}, ovf, e.ovf);
                end
                got++;
            end
            if (inFire) begin
                expQ.push_back(refModel(din1, din2, sub, sat));
                sent++;
            end
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput({tag, "_count"}, got, numOps);
        checkOutput({tag, "_leftover"}, expQ.size(), 0);
        watchQuiet({tag, "_extra"}, 8);
    endtask

    initial begin
        int   lat;
        vec_t v;

        vecs[0]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
        vecs[5]  = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
        vecs[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din1      = '0;
        din2      = '0;
        sub       = 1'b0;
        sat       = 1'b0;

        #2;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("post_reset_in_ready", in_ready, 1);

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        $display("[TB] stream with out_ready 1,0,0,1 pattern");
        streamTest("stream8", 8, 1'b0);
        $display("[TB] random stream with random out_ready");
        streamTest("rstream", 40, 1'b1);

        $display("[TB] flush with three operations in flight");
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            din1     = $urandom;
            din2     = $urandom;
            sub      = 1'b0;
            sat      = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        flush    = 1'b1;
        din1     = 32'h1234_5678;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        watchQuiet("flush_no_out", 10);
        runVector("post_flush", vecs[0]);

        $display("[TB] flush of a stalled result");
        out_ready = 1'b0;
        v = vecs[5];
        applyStimulus(v, lat);
        checkOutput("stall_hold_valid", out_valid, 1);
        @(negedge clk);
        checkOutput("stall_still_valid", out_valid, 1);
        checkOutput("stall_in_ready", in_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("stall_flushed", out_valid, 0);
        out_ready = 1'b1;
        watchQuiet("stall_flush_quiet", 6);

        $display("[TB] asynchronous reset mid-stream");
        out_ready = 1'b0;
        @(negedge clk);
        din1     = 32'h0000_0005;
        din2     = 32'h0000_0003;
        sub      = 1'b0;
        sat      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        din1 = 32'h0000_0011;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("rst_pre_valid", out_valid, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", out_valid, 0);
        checkOutput("rst_async_dout", dout, 0);
        checkOutput("rst_async_in_ready", in_ready, 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        watchQuiet("rst_no_stale", 10);
        runVector("post_rst", vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
